bp_be_issue_queue: RTL and testbench
====================================

Name: bp_be_issue_queue

Overview:
- Circular instruction buffer between the frontend queue interface and the backend hazard detector.
- Accepts fetched instruction packets and presents the oldest unissued one as the issue packet.
- Advances a speculative read pointer on dispatch and a committed pointer on retirement.
- Supports rewind (replay after commit-time exception/poison) and full flush (frontend redirect). Drives the credit status the detector uses for structural stalls.

Parameters:
- els_p, 8, number of entries; must be a power of two, >= 2.
- data_width_p, 64, issue payload width (instr + pc + metadata, packed by the instantiator).
- ptr_width_lp, $clog2(els_p)+1, derived; pointer width including the wrap bit.

Ports:
- clk_i  in  1  clock, all state updates on posedge.
- reset_i  in  1  synchronous, active-high reset.
- fe_v_i  in  1  enqueue request.
- fe_data_i  in  data_width_p  enqueue payload.
- fe_ready_o  out  1  space available (ready-then-valid).
- issue_v_o  out  1  an unissued entry is present.
- issue_data_o  out  data_width_p  payload at the read pointer.
- dispatch_v_i  in  1  detector accepted the current issue entry.
- commit_v_i  in  1  oldest dispatched entry retired.
- roll_v_i  in  1  rewind read pointer to committed pointer.
- clr_v_i  in  1  flush all entries.
- credits_full_o  out  1  queue holds els_p uncommitted entries.
- credits_empty_o  out  1  queue holds no uncommitted entries.
- outstanding_o  out  ptr_width_lp  entries dispatched but not committed (rptr - cptr).

Behaviour:
- State: payload RAM els_p x data_width_p.
- Pointers, all ptr_width_lp wide, modulo 2^ptr_width_lp; the low bits index the RAM:
  - wptr: write pointer.
  - rptr: speculative read pointer.
  - cptr: committed pointer.
- Invariant: cptr <= rptr <= wptr in wrap-aware distance.
- Reset: all pointers 0. Outputs are then fe_ready_o=1, issue_v_o=0, credits_empty_o=1, credits_full_o=0, outstanding_o=0. RAM contents are not reset.
- Reset mid-operation discards everything; the same values hold the cycle after reset deasserts.
- Full: full = (wptr - cptr == els_p). Then fe_ready_o = ~full and credits_full_o = full.
  - Both are from registered pointers only. A same-cycle commit does not raise ready.
- Empty: credits_empty_o = (wptr == cptr).
- Issue valid: issue_v_o = (rptr != wptr).
- Issue data: issue_data_o = RAM[rptr low bits], combinational read.
- Enqueue-to-issue latency is 1 cycle. Write-first bypass is not provided.
- Enqueue: when fe_v_i & fe_ready_o & ~clr_v_i, write RAM[wptr], then wptr+1.
- Dispatch: when dispatch_v_i & issue_v_o & ~roll_v_i & ~clr_v_i, rptr+1. dispatch_v_i with issue_v_o=0 is ignored.
- Commit: when commit_v_i & (rptr != cptr) & ~clr_v_i, cptr+1. Commit with nothing outstanding is ignored.
- Roll: rptr_n = cptr_n, where cptr_n includes a same-cycle commit. Same-cycle dispatch is dropped. Same-cycle enqueue proceeds normally.
- Clear: wptr, rptr, cptr all become 0. Same-cycle enqueue, dispatch, commit and roll are all dropped.
- Priority for rptr: clr > roll > dispatch.
- Wrap-around: pointers increment freely across 2^ptr_width_lp; no special case.
- Assertion (simulation only): els_p is a power of two.

Test Plan:
- els_p=4, enqueue A,B,C,D on consecutive cycles with no dispatch:
  - After the 4th: credits_full_o=1 and fe_ready_o=0. A 5th fe_v_i is ignored.
  - issue_data_o=A throughout.
- From the full state, dispatch 2, commit 1 (A):
  - Next cycle: credits_full_o=0, fe_ready_o=1, outstanding_o=1, issue_data_o=C.
- Dispatch A,B,C, commit A, then roll_v_i together with commit_v_i (B):
  - Next cycle: rptr=cptr, outstanding_o=0, issue_data_o=C, issue_v_o=1.
- clr_v_i with fe_v_i=1 and dispatch_v_i=1 in the same cycle:
  - Next cycle: issue_v_o=0, credits_empty_o=1, outstanding_o=0.
  - The enqueued payload is absent.
- Run 20 enqueue/dispatch/commit triples of values 0..19 through els_p=4:
  - Issue order is 0..19 across pointer wrap.
  - credits_empty_o=1 at the end.
- Assert reset_i for 1 cycle with 3 entries outstanding:
  - Next cycle: fe_ready_o=1, issue_v_o=0, credits_empty_o=1.
  - commit_v_i after reset is ignored (outstanding_o stays 0).

Source files
------------

// File: rtl/bp_be_issue_queue.sv
// Circular issue buffer between the frontend queue and the backend hazard detector.
// Keeps separate write, speculative-read and committed pointers so issued work can be replayed.
module bp_be_issue_queue #(
  parameter int els_p = 8,
  parameter int data_width_p = 64,
  localparam int ptr_width_lp = $clog2(els_p) + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    fe_v_i,
  input  logic [data_width_p-1:0] fe_data_i,
  output logic                    fe_ready_o,
  output logic                    issue_v_o,
  output logic [data_width_p-1:0] issue_data_o,
  input  logic                    dispatch_v_i,
  input  logic                    commit_v_i,
  input  logic                    roll_v_i,
  input  logic                    clr_v_i,
  output logic                    credits_full_o,
  output logic                    credits_empty_o,
  output logic [ptr_width_lp-1:0] outstanding_o
);

  localparam int idx_width_lp = ptr_width_lp - 1;
  localparam logic [ptr_width_lp-1:0] els_lp = ptr_width_lp'(els_p);

  logic [data_width_p-1:0] mem [els_p];
  logic [ptr_width_lp-1:0] wptr, rptr, cptr;
  logic [ptr_width_lp-1:0] wptr_n, rptr_n, cptr_n;
  logic full, enq, deq, cmt;

  // Status comes from registered pointers only, so a same-cycle commit cannot raise ready.
  assign full            = ((wptr - cptr) == els_lp);
  assign fe_ready_o      = ~full;
  assign credits_full_o  = full;
  assign credits_empty_o = (wptr == cptr);
  assign issue_v_o       = (rptr != wptr);
  assign issue_data_o    = mem[rptr[idx_width_lp-1:0]];
  assign outstanding_o   = rptr - cptr;

  assign enq = fe_v_i & fe_ready_o & ~clr_v_i;
  assign deq = dispatch_v_i & issue_v_o & ~roll_v_i & ~clr_v_i;
  assign cmt = commit_v_i & (rptr != cptr) & ~clr_v_i;

  // Roll lands on the committed pointer including any commit happening this cycle.
  always_comb begin
    wptr_n = wptr;
    cptr_n = cptr;
    rptr_n = rptr;
    if (clr_v_i) begin
      wptr_n = '0;
      cptr_n = '0;
      rptr_n = '0;
    end else begin
      if (enq) wptr_n = wptr + 1'b1;
      if (cmt) cptr_n = cptr + 1'b1;
      if (roll_v_i)
        rptr_n = cptr_n;
      else if (deq)
        rptr_n = rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr <= '0;
      rptr <= '0;
      cptr <= '0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      cptr <= cptr_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq)
      mem[wptr[idx_width_lp-1:0]] <= fe_data_i;
  end

  els_pow2_a: assert property (@(posedge clk_i) ((els_p & (els_p - 1)) == 0));

endmodule

// File: tb/tb_bp_be_issue_queue.sv
// Directed bench for bp_be_issue_queue with a dispatch-data scoreboard.
// Stimulus pushes the expected issue payload; a negedge monitor pops and compares on each dispatch.
module tb_bp_be_issue_queue;

  localparam int els_lp = 4;
  localparam int dw_lp = 16;
  localparam int pw_lp = $clog2(els_lp) + 1;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  logic fe_v_i = 1'b0;
  logic [dw_lp-1:0] fe_data_i = '0;
  logic fe_ready_o;
  logic issue_v_o;
  logic [dw_lp-1:0] issue_data_o;
  logic dispatch_v_i = 1'b0;
  logic commit_v_i = 1'b0;
  logic roll_v_i = 1'b0;
  logic clr_v_i = 1'b0;
  logic credits_full_o;
  logic credits_empty_o;
  logic [pw_lp-1:0] outstanding_o;

  int checks = 0;
  int errors = 0;
  logic [dw_lp-1:0] sb [$];

  bp_be_issue_queue #(.els_p(els_lp), .data_width_p(dw_lp)) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .fe_v_i(fe_v_i),
    .fe_data_i(fe_data_i),
    .fe_ready_o(fe_ready_o),
    .issue_v_o(issue_v_o),
    .issue_data_o(issue_data_o),
    .dispatch_v_i(dispatch_v_i),
    .commit_v_i(commit_v_i),
    .roll_v_i(roll_v_i),
    .clr_v_i(clr_v_i),
    .credits_full_o(credits_full_o),
    .credits_empty_o(credits_empty_o),
    .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  // Every accepted dispatch must present the next payload the stimulus expected.
  always @(negedge clk_i) begin
    if (!reset_i && dispatch_v_i && issue_v_o && !roll_v_i && !clr_v_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL dispatch_unexpected: got data %0h, expected no dispatch", issue_data_o);
      end else begin
        logic [dw_lp-1:0] exp;
        exp = sb.pop_front();
        if (issue_data_o !== exp) begin
          errors++;
          $display("[TB] FAIL dispatch_data: got %0h, expected %0h", issue_data_o, exp);
        end
      end
    end
  end

  task automatic applyStimulus(input logic fe_v, input logic [dw_lp-1:0] data,
                               input logic disp, input logic cmt, input logic roll,
                               input logic clr, input logic rst);
    fe_v_i = fe_v;
    fe_data_i = data;
    dispatch_v_i = disp;
    commit_v_i = cmt;
    roll_v_i = roll;
    clr_v_i = clr;
    reset_i = rst;
    @(posedge clk_i);
    #1;
    fe_v_i = 1'b0;
    fe_data_i = '0;
    dispatch_v_i = 1'b0;
    commit_v_i = 1'b0;
    roll_v_i = 1'b0;
    clr_v_i = 1'b0;
    reset_i = 1'b0;
  endtask

  task automatic cmpBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic ready, input logic v,
                             input logic full, input logic empty, input logic [pw_lp-1:0] outs);
    cmpBit({name, ".fe_ready"}, fe_ready_o, ready);
    cmpBit({name, ".issue_v"}, issue_v_o, v);
    cmpBit({name, ".credits_full"}, credits_full_o, full);
    cmpBit({name, ".credits_empty"}, credits_empty_o, empty);
    checks++;
    if (outstanding_o !== outs) begin
      errors++;
      $display("[TB] FAIL %s.outstanding: got %0d, expected %0d", name, outstanding_o, outs);
    end
  endtask

  task automatic checkData(input string name, input logic [dw_lp-1:0] exp);
    checks++;
    if (issue_data_o !== exp) begin
      errors++;
      $display("[TB] FAIL %s.issue_data: got %0h, expected %0h", name, issue_data_o, exp);
    end
  endtask

  initial begin
    logic [dw_lp-1:0] vals [4];
    vals[0] = 16'h00A1; vals[1] = 16'h00B2; vals[2] = 16'h00C3; vals[3] = 16'h00D4;

    applyStimulus(0, '0, 0, 0, 0, 0, 1);
    checkOutput("reset", 1, 0, 0, 1, 0);

    // Dispatch and commit on an empty queue must be ignored.
    applyStimulus(0, '0, 1, 1, 0, 0, 0);
    checkOutput("idle_ignore", 1, 0, 0, 1, 0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, vals[i], 0, 0, 0, 0, 0);
      checkData("fill", vals[0]);
    end
    checkOutput("full", 0, 1, 1, 0, 0);
    applyStimulus(1, 16'h00E5, 0, 0, 0, 0, 0);
    checkOutput("full_5th", 0, 1, 1, 0, 0);
    checkData("full_5th", vals[0]);

    sb.push_back(vals[0]);
    applyStimulus(0, '0, 1, 0, 0, 0, 0);
    sb.push_back(vals[1]);
    applyStimulus(0, '0, 1, 0, 0, 0, 0);
    applyStimulus(0, '0, 0, 1, 0, 0, 0);
    checkOutput("after_commit", 1, 1, 0, 0, 1);
    checkData("after_commit", vals[2]);

    // Clear drops the same-cycle enqueue and dispatch.
    applyStimulus(1, 16'h00EE, 1, 0, 0, 1, 0);
    checkOutput("clear", 1, 0, 0, 1, 0);
    applyStimulus(1, 16'h0055, 0, 0, 0, 0, 0);
    checkData("post_clear", 16'h0055);
    applyStimulus(1, 16'h0066, 0, 0, 0, 0, 0);
    sb.push_back(16'h0055);
    applyStimulus(0, '0, 1, 0, 0, 0, 0);
    sb.push_back(16'h0066);
    applyStimulus(0, '0, 1, 1, 0, 0, 0);
    applyStimulus(0, '0, 0, 1, 0, 0, 0);
    checkOutput("post_clear_drain", 1, 0, 0, 1, 0);

    applyStimulus(1, 16'h0071, 0, 0, 0, 0, 0);
    applyStimulus(1, 16'h0072, 0, 0, 0, 0, 0);
    applyStimulus(1, 16'h0073, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(dw_lp'(16'h0071 + i));
      applyStimulus(0, '0, 1, 0, 0, 0, 0);
    end
    checkOutput("pre_roll", 1, 0, 0, 0, 3);
    applyStimulus(0, '0, 0, 1, 0, 0, 0);
    applyStimulus(0, '0, 1, 1, 1, 0, 0);
    checkOutput("roll", 1, 1, 0, 0, 0);
    checkData("roll", 16'h0073);
    sb.push_back(16'h0073);
    applyStimulus(0, '0, 1, 0, 0, 0, 0);
    applyStimulus(0, '0, 0, 1, 0, 0, 0);
    checkOutput("roll_drain", 1, 0, 0, 1, 0);

    // Pipelined enqueue/dispatch/commit of 0..19 wraps the pointers several times.
    for (int k = 0; k < 22; k++) begin
      if (k >= 1 && k <= 20) sb.push_back(dw_lp'(k - 1));
      applyStimulus(k < 20, dw_lp'(k), (k >= 1 && k <= 20), (k >= 2), 0, 0, 0);
    end
    checkOutput("stream_end", 1, 0, 0, 1, 0);

    for (int i = 0; i < 3; i++) applyStimulus(1, dw_lp'(16'h0090 + i), 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(dw_lp'(16'h0090 + i));
      applyStimulus(0, '0, 1, 0, 0, 0, 0);
    end
    checkOutput("pre_reset", 1, 0, 0, 0, 3);
    applyStimulus(0, '0, 0, 0, 0, 0, 1);
    checkOutput("mid_reset", 1, 0, 0, 1, 0);
    applyStimulus(0, '0, 0, 1, 0, 0, 0);
    checkOutput("commit_after_reset", 1, 0, 0, 1, 0);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
